// File: rtl/mips_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : mips_mem_pkg                                             |
// | Brief   : Shared types and constants for the data-memory responder |
// |           (FSM states, word/byte-enable widths, address slicing).  |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package mips_mem_pkg;

  localparam int WORD_W     = 32;
  localparam int BE_W       = WORD_W / 8;
  localparam int ADDR_W     = 32;
  localparam int BYTE_OFF_W = 2;   // byte offset bits inside a word
  localparam int CNT_W      = 4;   // wait counter covers 0..15

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

  // True when a byte address does not point at the start of a word
  function automatic logic addr_misaligned(input logic [ADDR_W-1:0] addr);
    return addr[BYTE_OFF_W-1:0] != '0;
  endfunction

endpackage : mips_mem_pkg
`default_nettype wire

// File: rtl/sp_ram_be.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : sp_ram_be                                                |
// | Brief   : Single-port synchronous RAM, per-byte write enable,      |
// |           registered read. Contents are never reset.               |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module sp_ram_be
  import mips_mem_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [WORD_W-1:0]    wdata_i,
  input  logic [BE_W-1:0]      be_i,
  output logic [WORD_W-1:0]    rdata_o
);

  logic [WORD_W-1:0] mem_q [0:(1<<ADDR_BITS)-1];
  logic [WORD_W-1:0] rdata_q;

  // One access per enabled cycle: byte-masked write, or whole-word read into the output register
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule : sp_ram_be
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : data_mem_responder                                       |
// | Brief   : Valid/ready load/store responder for the core data port  |
// |           with programmable wait states over a byte-enable RAM.    |
// |           Define MEM_ERR_CHECK_EN to flag misaligned/out-of-range  |
// |           accesses via rsp_err (store suppressed, rdata = 0).      |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam bit               ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam int               IDX_LO    = BYTE_OFF_W;
  localparam int               IDX_HI    = DEPTH_LOG2 + BYTE_OFF_W - 1;

  mem_state_t              state_q;
  logic                    req_ready_q;
  logic                    rsp_valid_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    write_q;
  logic                    err_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [WORD_W-1:0]       wdata_q;
  logic [BE_W-1:0]         be_q;

  logic [DEPTH_LOG2-1:0]   idx_in;
  logic                    err_in;
  logic                    accept;
  logic                    acc_now;
  logic                    acc_wait;
  logic                    ram_en_d;
  logic                    ram_we_d;
  logic [DEPTH_LOG2-1:0]   ram_idx_d;
  logic [WORD_W-1:0]       ram_wdata_d;
  logic [BE_W-1:0]         ram_be_d;
  logic [WORD_W-1:0]       ram_rdata;

  assign idx_in = req_addr[IDX_HI:IDX_LO];

`ifdef MEM_ERR_CHECK_EN
  assign err_in  = addr_misaligned(req_addr) || (|req_addr[ADDR_W-1:IDX_HI+1]);
`else
  // Offset and upper bits take no part in addressing: upper bits alias
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[ADDR_W-1:IDX_HI+1], req_addr[BYTE_OFF_W-1:0]};
  assign err_in  = 1'b0;
`endif

  assign accept   = (state_q == ST_IDLE) && req_valid && req_ready_q;
  // With zero wait states the access must happen on the accepting edge, straight from the inputs
  assign acc_now  = accept && ZERO_WAIT;
  assign acc_wait = (state_q == ST_WAIT) && (cnt_q == '0);

  // Reset gating keeps an in-flight store from committing on the reset edge
  assign ram_en_d    = !reset && (acc_now || acc_wait);
  assign ram_we_d    = acc_now ? (req_write && !err_in) : (write_q && !err_q);
  assign ram_idx_d   = acc_now ? idx_in    : idx_q;
  assign ram_wdata_d = acc_now ? req_wdata : wdata_q;
  assign ram_be_d    = acc_now ? req_be    : be_q;

  sp_ram_be #(
    .ADDR_BITS (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en_d),
    .we_i    (ram_we_d),
    .addr_i  (ram_idx_d),
    .wdata_i (ram_wdata_d),
    .be_i    (ram_be_d),
    .rdata_o (ram_rdata)
  );

  // Transaction FSM: latch request, count wait states, hold response until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            write_q     <= req_write;
            err_q       <= err_in;
            idx_q       <= idx_in;
            wdata_q     <= req_wdata;
            be_q        <= req_be;
            cnt_q       <= WAIT_INIT;
            req_ready_q <= 1'b0;
            if (ZERO_WAIT) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // RAM read register holds during RESP since the RAM is idle, so the data stays stable
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = (rsp_valid_q && !write_q && !err_q) ? ram_rdata : '0;
`ifdef MEM_ERR_CHECK_EN
  assign rsp_err   = rsp_valid_q && err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_data_mem_responder                                    |
// | Brief   : Directed self-checking bench for data_mem_responder      |
// |           (DEPTH_LOG2=10, WAIT_CYCLES=2).                          |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_err = 0;

  data_mem_responder #(
    .DEPTH_LOG2  (10),
    .WAIT_CYCLES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request and hold it until the accepting edge has passed
  task automatic accept_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be);
    int k;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    k = 0;
    while (!req_ready && k < 50) begin @(posedge clk); #1; k++; end
    if (k >= 50) chk("accept_timeout", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'hFFFF_FFFF; req_be = 4'hF;
  endtask

  // Count edges from acceptance to rsp_valid; also count samples where req_ready was high
  task automatic wait_rsp(output int lat, output int ready_hi);
    lat = 0; ready_hi = 0;
    while (!rsp_valid && lat < 50) begin
      if (req_ready) ready_hi++;
      @(posedge clk); #1; lat++;
    end
    if (req_ready) ready_hi++;
  endtask

  task automatic xact(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      output logic [31:0] rd, output logic er, output int lat, output int rhi);
    accept_req(w, a, d, be);
    wait_rsp(lat, rhi);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          rhi;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   {31'b0, rsp_err},   32'd0);

    // Basic store then load
    xact("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, rhi);
    chk("st10_rdata", rd, 32'h0);
    chk("st10_err",   {31'b0, er}, 32'd0);
    chk("st10_lat",   lat, 3);
    xact("ld10", 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, rhi);
    chk("ld10_rdata", rd, 32'hDEADBEEF);
    chk("ld10_err",   {31'b0, er}, 32'd0);
    // Latency: valid first at N+3, ready low from N+1 through N+3
    chk("ld10_lat",      lat, 3);
    chk("ld10_ready_lo", rhi, 0);
    chk("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("post_req_ready", {31'b0, req_ready}, 32'd1);

    // Partial byte-enable merge
    xact("st40a", 1'b1, 32'h40, 32'h11223344, 4'hF, rd, er, lat, rhi);
    xact("st40b", 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, rd, er, lat, rhi);
    xact("ld40", 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat, rhi);
    chk("ld40_rdata", rd, 32'h11BB33DD);

    // Store with no byte enables leaves memory intact
    xact("st40z", 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, rd, er, lat, rhi);
    chk("st40z_err", {31'b0, er}, 32'd0);
    xact("ld40z", 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat, rhi);
    chk("ld40z_rdata", rd, 32'h11BB33DD);

    // Back-pressure: response held while rsp_ready low; new request ignored
    accept_req(1'b0, 32'h40, 32'h0, 4'h0);
    wait_rsp(lat, rhi);
    chk("bp_lat", lat, 3);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40;
    req_wdata = 32'h0BAD0BAD; req_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_hold", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rdata_hold", rsp_rdata, 32'h11BB33DD);
      chk("bp_ready_lo",   {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_done_valid", {31'b0, rsp_valid}, 32'd0);
    xact("bp_ld", 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat, rhi);
    chk("bp_ignored_store", rd, 32'h11BB33DD);

    // Reset during WAIT of a store discards it
    xact("st20init", 1'b1, 32'h20, 32'h0, 4'hF, rd, er, lat, rhi);
    accept_req(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid_req_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("rstmid_no_rsp", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    xact("ld20", 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, rhi);
    chk("ld20_rdata", rd, 32'h0);

    // Error checking / aliasing
    xact("st0", 1'b1, 32'h0, 32'h55AA55AA, 4'hF, rd, er, lat, rhi);
`ifdef MEM_ERR_CHECK_EN
    xact("ld13", 1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat, rhi);
    chk("ld13_err",   {31'b0, er}, 32'd1);
    chk("ld13_rdata", rd, 32'h0);
    chk("ld13_lat",   lat, 3);
    xact("st1000", 1'b1, 32'h1000, 32'h12345678, 4'hF, rd, er, lat, rhi);
    chk("st1000_err", {31'b0, er}, 32'd1);
    xact("ld0", 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, rhi);
    chk("ld0_unchanged", rd, 32'h55AA55AA);
    chk("ld0_err", {31'b0, er}, 32'd0);
`else
    xact("st1000", 1'b1, 32'h1000, 32'h12345678, 4'hF, rd, er, lat, rhi);
    chk("st1000_err", {31'b0, er}, 32'd0);
    xact("ld0", 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, rhi);
    chk("ld0_aliased", rd, 32'h12345678);
    chk("ld0_err", {31'b0, er}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_data_mem_responder
`default_nettype wire
